// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encoding, frame width and parity helper for the UART transmitter
package uart_tx_pkg;
  localparam int DATA_W = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-request handshake and serial/status outputs of the UART transmitter
interface uart_tx_if;
  import uart_tx_pkg::*;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx;
  logic              busy;
  logic              done;
  modport master (output tx_start, tx_data, input tx, busy, done);
  modport slave  (input tx_start, tx_data, output tx, busy, done);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: bit-period counter; tick marks the last clock of each bit period
module uart_tx_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = (cnt == W'(CLKS_PER_BIT - 1));
  // count 0..CLKS_PER_BIT-1, held at zero while cleared, wrap on terminal count
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else        cnt <= (clear || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-to-frame serialiser (start, 8 data LSB first, optional parity, stop bits)
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     n_rst,
  uart_tx_if.slave bus
);
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              stop_cnt;
  logic              par;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic              tick;
  logic              stop_last;
  logic              accept;
  uart_tx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (state == IDLE),
    .tick  (tick)
  );
  assign stop_last = (state == STOP) && tick && (stop_cnt == 1'(STOP_BITS - 1));
  // a start request held across the final stop edge chains straight into the next frame
  assign accept  = bus.tx_start && ((state == IDLE) || stop_last);
  assign bus.tx   = tx_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  // frame sequencer with registered line and status outputs
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= stop_last;
      if (accept) begin
        state  <= START;
        shreg  <= bus.tx_data;
        par    <= parity_of(bus.tx_data, PARITY_ODD);
        busy_r <= 1'b1;
        tx_r   <= 1'b0;
      end else if (tick) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            tx_r    <= shreg[0];
          end
          DATA: begin
            shreg    <= shreg >> 1;
            bit_idx  <= (bit_idx == 3'd7) ? 3'd7 : bit_idx + 3'd1;
            state    <= (bit_idx != 3'd7) ? DATA : (PARITY_EN ? PARITY : STOP);
            tx_r     <= (bit_idx != 3'd7) ? shreg[1] : (PARITY_EN ? par : 1'b1);
            stop_cnt <= 1'b0;
          end
          PARITY: begin
            state    <= STOP;
            tx_r     <= 1'b1;
            stop_cnt <= 1'b0;
          end
          STOP: begin
            state    <= stop_last ? IDLE : STOP;
            busy_r   <= !stop_last;
            stop_cnt <= 1'b1;
            tx_r     <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitter configurations checked cycle by cycle against a frame model
module tb_uart_tx;
  localparam int C = 4;
  localparam int PE[3]  = '{1, 1, 0};
  localparam int ODD[3] = '{0, 1, 0};
  localparam int SB[3]  = '{1, 2, 1};
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  int vectors = 0;
  int miscompares = 0;
  uart_tx_if if_e ();
  uart_tx_if if_o ();
  uart_tx_if if_n ();
  assign if_e.tx_start = start;
  assign if_o.tx_start = start;
  assign if_n.tx_start = start;
  assign if_e.tx_data  = data;
  assign if_o.tx_data  = data;
  assign if_n.tx_data  = data;
  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1))
    dut_e (.clk(clk), .n_rst(n_rst), .bus(if_e));
  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2))
    dut_o (.clk(clk), .n_rst(n_rst), .bus(if_o));
  uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
    dut_n (.clk(clk), .n_rst(n_rst), .bus(if_n));
  logic otx[3];
  logic obusy[3];
  logic odone[3];
  assign otx[0] = if_e.tx;
  assign otx[1] = if_o.tx;
  assign otx[2] = if_n.tx;
  assign obusy[0] = if_e.busy;
  assign obusy[1] = if_o.busy;
  assign obusy[2] = if_n.busy;
  assign odone[0] = if_e.done;
  assign odone[1] = if_o.done;
  assign odone[2] = if_n.done;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d at %0t: observed %b expected %b", tag, i, $time, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_tx"}, i, otx[i], 1'b1);
      chk({tag, "_busy"}, i, obusy[i], 1'b0);
      chk({tag, "_done"}, i, odone[i], 1'b0);
    end
  endtask

  // line level o cycles into a frame: bit slot o/C of {start, d[0..7], [parity], stop...}
  function automatic logic bit_at(input int i, input logic [7:0] d, input int o);
    int b;
    b = o / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PE[i] == 1 && b == 9) return (ODD[i] == 1) ? ~^d : ^d;
    return 1'b1;
  endfunction

  // nf frames back to back from the acceptance edge, then idle
  task automatic run(input int nf, input logic [7:0] d0, input logic [7:0] d1,
                     input int hold, input int pulse_at, input int ncyc);
    int l;
    int f;
    int o;
    @(negedge clk);
    start = 1'b1;
    data  = d0;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      #1;
      start = (k < hold) || (k == pulse_at);
      data  = (k == pulse_at) ? 8'hFF : ((nf == 2) ? d1 : ~d0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        l = (9 + PE[i] + SB[i]) * C;
        f = k / l;
        if (f < nf) begin
          o = k - f * l;
          chk("tx", i, otx[i], bit_at(i, (f == 0) ? d0 : d1, o));
          chk("busy", i, obusy[i], 1'b1);
          chk("done", i, odone[i], (k > 0) && (o == 0));
        end else begin
          chk("tx_idle", i, otx[i], 1'b1);
          chk("busy_idle", i, obusy[i], 1'b0);
          chk("done_end", i, odone[i], k == nf * l);
        end
      end
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    start = 1'b1;
    data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset");
    end
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    chk_idle("released");
    run(1, 8'hA5, 8'h00, 0, -1, 52);
    run(1, 8'h01, 8'h00, 0, -1, 52);
    run(1, 8'h00, 8'h00, 0, -1, 52);
    run(1, 8'h3C, 8'h00, 0, 10, 52);
    run(2, 8'h55, 8'hAA, 50, -1, 100);
    @(negedge clk);
    start = 1'b1;
    data  = 8'h3C;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #5 n_rst = 1'b0;
    #1 chk_idle("async_reset");
    @(negedge clk);
    chk_idle("in_reset");
    n_rst = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");
    run(1, 8'h81, 8'h00, 0, -1, 52);
    repeat (8) run(1, 8'($urandom), 8'h00, 0, int'($urandom_range(1, 35)), 52);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
